// File: rtl/param_stream_buffer.sv
// param_stream_buffer: fills a DEPTH-word parameter memory from a valid/ready
// stream of PARALLELISM-element beats. A 2-cycle read port serves the compute
// side, and reads are allowed while the buffer is still filling.
// Optional feature: define PARAM_STREAM_BUFFER_CHECKSUM_EN to add a running XOR
// checksum of the words written since the last fill start.
//
// state | meaning
// FILL  | accepting beats into mem[wr_ptr]; ready unless clear is pulsed
// FULL  | all DEPTH words written; ready low until clear
module param_stream_buffer #(
    parameter int PRECISION   = 16,
    parameter int PARALLELISM = 1,
    parameter int DEPTH       = 32,
    parameter int AWIDTH      = $clog2(DEPTH) + 1,
    parameter int WWIDTH      = PRECISION * PARALLELISM
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PRECISION-1:0] data_in [PARALLELISM],
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    input  logic                 clear,
    output logic                 full,
    input  logic [AWIDTH-1:0]    address0,
    input  logic                 ce0,
    output logic [WWIDTH-1:0]    q0,
    output logic [WWIDTH-1:0]    checksum
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_FILL = 1'b0, S_FULL = 1'b1} state_t;

    state_t              state_q;
    logic [AWIDTH-1:0]   wr_ptr_q;
    logic                full_q;
    logic [WWIDTH-1:0]   stage1_q;
    logic [WWIDTH-1:0]   q0_q;
    logic [WWIDTH-1:0]   mem [DEPTH];

    logic [WWIDTH-1:0]   word_in;
    logic [WWIDTH-1:0]   rd_word;
    logic                wr_en;

    // A clear cycle never accepts a beat, so ready drops combinationally with it.
    assign data_in_ready = (state_q == S_FILL) && !clear;
    assign wr_en         = data_in_valid && data_in_ready && !rst;
    assign full          = full_q;
    assign q0            = q0_q;

    // Pack elements so element j lands in word bits [PRECISION*j +: PRECISION].
    always_comb begin
        word_in = '0;
        for (int j = 0; j < PARALLELISM; j++) begin
            word_in[PRECISION*j +: PRECISION] = data_in[j];
        end
    end

    // Out-of-range addresses read as zero so they cannot index past the array.
    always_comb begin
        rd_word = '0;
        if (address0 < AWIDTH'(DEPTH)) begin
            rd_word = mem[address0[IW-1:0]];
        end
    end

    // Fill/full state machine with the write pointer and registered full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FILL;
            wr_ptr_q <= '0;
            full_q   <= 1'b0;
        end else if (clear) begin
            state_q  <= S_FILL;
            wr_ptr_q <= '0;
            full_q   <= 1'b0;
        end else if (wr_en) begin
            if (wr_ptr_q == AWIDTH'(DEPTH - 1)) begin
                state_q  <= S_FULL;
                wr_ptr_q <= '0;
                full_q   <= 1'b1;
            end else begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
        end
    end

    // Parameter storage; contents deliberately survive reset and clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[IW-1:0]] <= word_in;
        end
    end

    // Two-stage read pipeline; both stages hold while ce0 is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_q <= '0;
            q0_q     <= '0;
        end else if (ce0) begin
            stage1_q <= rd_word;
            q0_q     <= stage1_q;
        end
    end

`ifdef PARAM_STREAM_BUFFER_CHECKSUM_EN
    logic [WWIDTH-1:0] checksum_q;

    // Running XOR of every accepted word since the last reset or clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            checksum_q <= '0;
        end else if (wr_en) begin
            checksum_q <= checksum_q ^ word_in;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_param_stream_buffer.sv
// Bench for param_stream_buffer at DEPTH=4, PARALLELISM=2, PRECISION=16.
// A small model tracks state, pointer, memory and checksum; read results are
// queued when a read is issued and popped when q0 is due.
module tb_param_stream_buffer;

    localparam int PREC = 16;
    localparam int PAR  = 2;
    localparam int DEP  = 4;
    localparam int AW   = $clog2(DEP) + 1;
    localparam int WW   = PREC * PAR;

    logic            clk;
    logic            rst;
    logic [PREC-1:0] din [PAR];
    logic            vld;
    logic            rdy;
    logic            clear;
    logic            full;
    logic [AW-1:0]   addr;
    logic            ce0;
    logic [WW-1:0]   q0;
    logic [WW-1:0]   checksum;

    int checks;
    int failures;

    logic            m_full;
    logic [AW-1:0]   m_ptr;
    logic [WW-1:0]   m_csum;
    logic [WW-1:0]   m_mem [DEP];
    logic [WW-1:0]   sb [$];

    param_stream_buffer #(
        .PRECISION  (PREC),
        .PARALLELISM(PAR),
        .DEPTH      (DEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (din),
        .data_in_valid(vld),
        .data_in_ready(rdy),
        .clear        (clear),
        .full         (full),
        .address0     (addr),
        .ce0          (ce0),
        .q0           (q0),
        .checksum     (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; the model updates from the inputs held across the edge.
    task automatic tick();
        bit            acc;
        logic [WW-1:0] w;
        acc = !rst && !m_full && !clear && vld;
        w   = {din[1], din[0]};
        @(posedge clk);
        if (rst || clear) begin
            m_full = 1'b0;
            m_ptr  = '0;
            m_csum = '0;
        end else if (acc) begin
            m_mem[m_ptr[1:0]] = w;
`ifdef PARAM_STREAM_BUFFER_CHECKSUM_EN
            m_csum = m_csum ^ w;
`endif
            if (m_ptr == AW'(DEP - 1)) begin
                m_full = 1'b1;
                m_ptr  = '0;
            end else begin
                m_ptr = m_ptr + 1'b1;
            end
        end
        #1;
    endtask

    task automatic set_beat(input logic [PREC-1:0] e1, input logic [PREC-1:0] e0, input logic v);
        din[1] = e1;
        din[0] = e0;
        vld    = v;
    endtask

    task automatic check_state(input string tag);
        checks++;
        if (full !== m_full) begin
            failures++;
            $display("FAIL %s full actual=%0b expected=%0b", tag, full, m_full);
        end
        checks++;
        if (dut.wr_ptr_q !== m_ptr) begin
            failures++;
            $display("FAIL %s wr_ptr actual=%0d expected=%0d", tag, dut.wr_ptr_q, m_ptr);
        end
    endtask

    // Issue a read of addr a with ce0 high for two edges, then compare q0.
    task automatic read_word(input logic [AW-1:0] a, input string tag);
        logic [WW-1:0] exp;
        sb.push_back(m_mem[a[1:0]]);
        addr = a;
        ce0  = 1'b1;
        tick();
        tick();
        ce0 = 1'b0;
        exp = sb.pop_front();
        checks++;
        if (q0 !== exp) begin
            failures++;
            $display("FAIL %s q0 actual=%08h expected=%08h", tag, q0, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; ce0 = 1'b0; addr = '0;
        set_beat(16'h0, 16'h0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check_state("reset");
        checks++;
        if (rdy !== 1'b1) begin failures++; $display("FAIL reset ready actual=%0b expected=1", rdy); end
        checks++;
        if (q0 !== '0) begin failures++; $display("FAIL reset q0 actual=%08h expected=0", q0); end
        checks++;
        if (checksum !== '0) begin failures++; $display("FAIL reset checksum actual=%08h expected=0", checksum); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEP; i++) begin
            set_beat(PREC'(2 * i + 2), PREC'(2 * i + 1), 1'b1);
            #1;
            checks++;
            if (rdy !== 1'b1) begin failures++; $display("FAIL fill ready beat%0d actual=%0b expected=1", i, rdy); end
            tick();
            check_state("fill");
        end
        vld = 1'b0;
        checks++;
        if (full !== 1'b1 || rdy !== 1'b0) begin
            failures++;
            $display("FAIL fill_end full/ready actual=%0b/%0b expected=1/0", full, rdy);
        end
        read_word(AW'(2), "fill_read2");
        checks++;
        if (q0 !== 32'h0006_0005) begin failures++; $display("FAIL fill_q0_const actual=%08h expected=00060005", q0); end
        // ce0 low: pipeline holds even when the address moves
        addr = AW'(0);
        tick(); tick();
        checks++;
        if (q0 !== 32'h0006_0005) begin failures++; $display("FAIL hold q0 actual=%08h expected=00060005", q0); end
        // valid while full is ignored
        set_beat(16'hDEAD, 16'hBEEF, 1'b1);
        tick();
        vld = 1'b0;
        check_state("full_ignore");
        read_word(AW'(0), "full_ignore_read0");
    endtask

    task automatic test_clear_full();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        check_state("clear_full");
        checks++;
        if (rdy !== 1'b1) begin failures++; $display("FAIL clear_full ready actual=%0b expected=1", rdy); end
        // write addr 0 while reading addr 0: the read sees the old word
        sb.push_back(m_mem[0]);
        set_beat(16'hAAAA, 16'hAAAA, 1'b1);
        addr = AW'(0);
        ce0  = 1'b1;
        tick();
        vld = 1'b0;
        tick();
        ce0 = 1'b0;
        begin
            logic [WW-1:0] exp;
            exp = sb.pop_front();
            checks++;
            if (q0 !== exp) begin failures++; $display("FAIL rw_collision q0 actual=%08h expected=%08h", q0, exp); end
        end
        read_word(AW'(0), "refill_read0");
        checks++;
        if (q0 !== 32'hAAAA_AAAA) begin failures++; $display("FAIL refill_const q0 actual=%08h expected=aaaaaaaa", q0); end
        for (int i = 1; i < DEP; i++) begin
            set_beat(16'hAAAA, PREC'(16'hA000 + i), 1'b1);
            tick();
        end
        vld = 1'b0;
        check_state("refill_full");
    endtask

    task automatic test_gaps();
        int acc_n;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        acc_n = 0;
        for (int c = 0; c < 2 * DEP; c++) begin
            set_beat(PREC'(16'h1100 + c), PREC'(16'h2200 + c), (c % 2) == 0);
            if ((c % 2) == 0) acc_n++;
            tick();
            check_state("gaps");
            checks++;
            if (full !== (acc_n == DEP)) begin
                failures++;
                $display("FAIL gaps full_count cycle%0d actual=%0b expected=%0b", c, full, acc_n == DEP);
            end
        end
        vld = 1'b0;
        read_word(AW'(3), "gaps_read3");
    endtask

    task automatic test_clear_valid();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        set_beat(16'h1234, 16'h5678, 1'b1);
        tick();
        set_beat(16'h5555, 16'h5555, 1'b1);
        clear = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b0) begin failures++; $display("FAIL clear_valid ready actual=%0b expected=0", rdy); end
        tick();
        clear = 1'b0;
        vld   = 1'b0;
        check_state("clear_valid");
        read_word(AW'(1), "clear_valid_read1");
        read_word(AW'(0), "clear_valid_read0");
    endtask

    task automatic test_checksum();
        logic [WW-1:0] exp_final;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            set_beat(16'h0, PREC'(1 << i), 1'b1);
            tick();
            checks++;
            if (checksum !== m_csum) begin
                failures++;
                $display("FAIL checksum beat%0d actual=%08h expected=%08h", i, checksum, m_csum);
            end
        end
        vld = 1'b0;
`ifdef PARAM_STREAM_BUFFER_CHECKSUM_EN
        exp_final = 32'h0000_000F;
`else
        exp_final = '0;
`endif
        checks++;
        if (checksum !== exp_final) begin failures++; $display("FAIL checksum_final actual=%08h expected=%08h", checksum, exp_final); end
    endtask

    task automatic test_reset_mid();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_beat(16'h3300, PREC'(16'h4400 + i), 1'b1);
            tick();
        end
        read_word(AW'(0), "pre_rst_read0");
        set_beat(16'h7777, 16'h7777, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vld = 1'b0;
        check_state("rst_mid");
        checks++;
        if (q0 !== '0) begin failures++; $display("FAIL rst_mid q0 actual=%08h expected=0", q0); end
        for (int i = 0; i < DEP; i++) begin
            set_beat(16'h6600, PREC'(16'h9900 + i), 1'b1);
            tick();
            checks++;
            if (full !== (i == DEP - 1)) begin
                failures++;
                $display("FAIL rst_mid_refill full beat%0d actual=%0b expected=%0b", i, full, i == DEP - 1);
            end
        end
        vld = 1'b0;
        read_word(AW'(2), "rst_mid_read2");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_full   = 1'b0;
        m_ptr    = '0;
        m_csum   = '0;
        for (int i = 0; i < DEP; i++) m_mem[i] = 'x;
        test_reset();
        test_fill();
        test_clear_full();
        test_gaps();
        test_clear_valid();
        test_checksum();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
